motor_pulse_receiver: RTL and testbench
=======================================

# motor_pulse_receiver

Receiving end of the periodic motor-command pulses (`forward_rst`, `reverse_rst`, `stop_rst`) produced by the continuous motor control block. Latches the last commanded direction and drives an H-bridge pair (`in1`/`in2`) with PWM. Enforces a dead-time on every entry into a drive direction. Acts as a watchdog: if the command pulses stop arriving, it falls back to stop.

## Interface
- `TIMEOUT_CYCLES`, default 1<<23: cycles without a valid pulse before forced stop; two refresh periods of 1<<22.
- `DEADTIME_CYCLES`, default 50_000: both bridge inputs held low before driving (1 ms at 50 MHz).
- `PWM_PERIOD`, default 2500: PWM period in cycles (20 kHz at 50 MHz).
- `DUTY_W`, default 12: width of the duty input.
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: synchronous, active-high reset.
- `forward_rst` in 1: one-cycle forward command pulse.
- `reverse_rst` in 1: one-cycle reverse command pulse.
- `stop_rst` in 1: one-cycle stop command pulse.
- `duty` in DUTY_W: PWM high time in cycles, unsigned.
- `in1` out 1: H-bridge forward input, registered.
- `in2` out 1: H-bridge reverse input, registered.
- `motor_state` out 2: current state; 00 fwd, 01 rev, 10 stop, 11 dead-time.
- `timeout_flag` out 1: sticky, set when the watchdog fires.
- `pulse_err` out 1: one-cycle strobe when more than one command pulse is seen in the same cycle.

## Operation
- **States:** S_STOP, S_DEAD, S_FWD, S_REV. S_DEAD holds a registered `target` (fwd or rev).
- **Valid pulse:** exactly one of the three pulse inputs is high in a cycle.
- **Simultaneous pulses:** stop wins if `stop_rst` is among them; forward+reverse without stop is treated as stop. `pulse_err`=1 for that cycle. The cycle still counts as a valid stop for the watchdog.
- **Transitions:**
  - S_STOP + fwd/rev → S_DEAD, target = that direction.
  - S_FWD + rev → S_DEAD, target=rev. S_REV + fwd → S_DEAD, target=fwd.
  - S_FWD + fwd, or S_REV + rev → stay; watchdog refresh only.
  - Any state + stop → S_STOP immediately, no dead-time.
  - S_DEAD + same-target pulse → continue, dead-time counter not restarted.
  - S_DEAD + opposite pulse → retarget and restart dead-time counter at 0.
  - S_DEAD after DEADTIME_CYCLES cycles → target state.
- **Watchdog:**
  - Counter cleared by any valid pulse; otherwise increments, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES while in S_FWD/S_REV/S_DEAD: → S_STOP and `timeout_flag` set.
  - In S_STOP the counter runs but causes no action.
  - `timeout_flag` clears on the next valid fwd or rev pulse.
- **PWM:**
  - Free-running counter 0..PWM_PERIOD-1, wraps to 0.
  - `duty` sampled into `duty_q` when the counter is 0, saturated to PWM_PERIOD.
  - `pwm_hi` = counter < `duty_q`. duty=0 → always low; duty ≥ PWM_PERIOD → always high.
- **Outputs:** `in1` = (state==S_FWD) & `pwm_hi`; `in2` = (state==S_REV) & `pwm_hi`. `in1` and `in2` are never both 1.

## Timing
- **Reset:** state S_STOP, `motor_state`=10, `in1`=`in2`=0, `timeout_flag`=0, `pulse_err`=0. Watchdog, dead-time counter, PWM counter and `duty_q` all 0.
- **Pulse latency:** pulse high at edge N → `motor_state` updated after edge N.
- **Dead-time:** S_DEAD lasts exactly DEADTIME_CYCLES cycles. `in1`/`in2` reflect the new state one cycle after `motor_state`, because they are registered from state and `pwm_hi`.
- **Stop latency:** stop pulse at edge N → `in1`=`in2`=0 after edge N+1.
- **Watchdog timing:** the last valid pulse at edge N fires the watchdog at edge N+TIMEOUT_CYCLES.
- **Pulse vs timeout:** a valid pulse in the same cycle as the timeout wins; the watchdog does not fire.
- **Reset precedence:** `rst` overrides everything, including mid dead-time and mid PWM period.

## Structure
- **Package `motor_pkg`:**
  - direction encoding: 2'b00 fwd, 2'b01 rev, 2'b10 stop.
  - `motor_state_t` enum.
  - `REFRESH_CYCLES` = 1<<22, shared with the sender.
  - `DEFAULT_TIMEOUT` = 2*REFRESH_CYCLES.
- **Sub-module `pwm_generator`:** counter, duty sampling and saturation; output `pwm_hi`.
- Top level holds the FSM, dead-time counter and watchdog.

## Test plan
Bench parameters: TIMEOUT_CYCLES=100, DEADTIME_CYCLES=4, PWM_PERIOD=10, duty=3.
- **Start forward:** reset, then `forward_rst` pulse → `motor_state`=11 for 4 cycles, then 00. `in1` high 3 of every 10 cycles; `in2` always 0.
- **Direction reversal:** forward running, then `reverse_rst` → `in1` low within 2 cycles, 4 dead-time cycles with both low, then `in2` PWM at 3/10.
- **Watchdog:** forward, refresh pulses every 50 cycles, then pulses stop → S_STOP exactly 100 cycles after the last pulse and `timeout_flag`=1. A later `forward_rst` clears the flag.
- **Simultaneous pulses:** `forward_rst`+`stop_rst` in one cycle while in S_REV → S_STOP, `pulse_err` high for 1 cycle. `forward_rst`+`reverse_rst` → S_STOP, `pulse_err` high.
- **Duty edges:** duty=0 → `in1` never high. duty=15 → `in1` constantly high in S_FWD. Duty changed mid-period takes effect only at the next counter wrap.
- **Reset mid dead-time:** `rst` asserted during S_DEAD → all outputs at reset values next cycle; a later forward pulse takes the full 4 dead-time cycles again.

Source files
------------

// File: rtl/motor_pkg.sv
// motor_pkg: direction/state encodings and refresh timing shared by the motor command sender and receiver
package motor_pkg;
    typedef enum logic [1:0] {DIR_FWD = 2'b00, DIR_REV = 2'b01, DIR_STOP = 2'b10} dir_t;
    typedef enum logic [1:0] {S_FWD = 2'b00, S_REV = 2'b01, S_STOP = 2'b10, S_DEAD = 2'b11} motor_state_t;
    localparam int REFRESH_CYCLES = 1 << 22;
    localparam int DEFAULT_TIMEOUT = 2 * REFRESH_CYCLES;
    function automatic motor_state_t dir_to_state(input dir_t d);
        return (d == DIR_REV) ? S_REV : S_FWD;
    endfunction
endpackage

// File: rtl/pwm_generator.sv
// pwm_generator: free-running PWM counter with duty captured once per period and saturated to the period
module pwm_generator #(
    parameter int PWM_PERIOD = 2500,
    parameter int DUTY_W     = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm_hi
);
    localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int QW = $clog2(PWM_PERIOD + 1);
    logic [CW-1:0] r_cnt;
    logic [QW-1:0] r_duty_q;
    logic [QW-1:0] w_duty_sat;
    logic [QW-1:0] w_duty_eff;
    logic          w_wrap;
    assign w_wrap     = r_cnt == '0;
    assign w_duty_sat = (32'(duty) >= 32'(PWM_PERIOD)) ? QW'(PWM_PERIOD) : QW'(duty);
    // the freshly sampled duty already governs the first cycle of its period
    assign w_duty_eff = w_wrap ? w_duty_sat : r_duty_q;
    assign pwm_hi     = QW'(r_cnt) < w_duty_eff;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_duty_q <= '0;
        end else begin
            r_cnt    <= (r_cnt == CW'(PWM_PERIOD - 1)) ? '0 : r_cnt + CW'(1);
            r_duty_q <= w_wrap ? w_duty_sat : r_duty_q;
        end
    end
endmodule

// File: rtl/motor_pulse_receiver.sv
// motor_pulse_receiver: turns periodic motor command pulses into dead-timed, watchdog-guarded H-bridge PWM drive
module motor_pulse_receiver
    import motor_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT,
    parameter int DEADTIME_CYCLES = 50_000,
    parameter int PWM_PERIOD      = 2500,
    parameter int DUTY_W          = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              forward_rst,
    input  logic              reverse_rst,
    input  logic              stop_rst,
    input  logic [DUTY_W-1:0] duty,
    output logic              in1,
    output logic              in2,
    output logic [1:0]        motor_state,
    output logic              timeout_flag,
    output logic              pulse_err
);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DTW = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;
    motor_state_t   r_state;
    dir_t           r_target;
    logic [WDW-1:0] r_wd;
    logic [DTW-1:0] r_dt;
    logic           r_in1;
    logic           r_in2;
    logic           r_timeout;
    logic           r_pulse_err;
    logic           w_multi;
    logic           w_valid;
    logic           w_stop;
    logic           w_fwd;
    logic           w_rev;
    logic           w_drive;
    logic           w_fire;
    logic           w_dt_done;
    logic           w_pwm_hi;
    dir_t           w_dir;
    // colliding pulses collapse to stop but still refresh the watchdog
    assign w_multi   = (forward_rst & reverse_rst) | (forward_rst & stop_rst) | (reverse_rst & stop_rst);
    assign w_valid   = forward_rst | reverse_rst | stop_rst;
    assign w_stop    = stop_rst | w_multi;
    assign w_fwd     = forward_rst & ~w_stop;
    assign w_rev     = reverse_rst & ~w_stop;
    assign w_drive   = w_fwd | w_rev;
    assign w_dir     = w_fwd ? DIR_FWD : DIR_REV;
    assign w_fire    = ~w_valid & (r_wd == WDW'(TIMEOUT_CYCLES - 1)) & (r_state != S_STOP);
    assign w_dt_done = r_dt == DTW'(DEADTIME_CYCLES - 1);
    pwm_generator #(
        .PWM_PERIOD(PWM_PERIOD),
        .DUTY_W    (DUTY_W)
    ) u_pwm (
        .clk   (clk),
        .rst   (rst),
        .duty  (duty),
        .pwm_hi(w_pwm_hi)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_STOP;
            r_target    <= DIR_FWD;
            r_wd        <= '0;
            r_dt        <= '0;
            r_in1       <= 1'b0;
            r_in2       <= 1'b0;
            r_timeout   <= 1'b0;
            r_pulse_err <= 1'b0;
        end else begin
            r_pulse_err <= w_multi;
            r_wd        <= w_valid ? '0 : ((r_wd == WDW'(TIMEOUT_CYCLES)) ? r_wd : r_wd + WDW'(1));
            r_timeout   <= w_drive ? 1'b0 : (r_timeout | w_fire);
            r_in1       <= (r_state == S_FWD) & w_pwm_hi;
            r_in2       <= (r_state == S_REV) & w_pwm_hi;
            r_dt        <= (r_state == S_DEAD) ? r_dt + DTW'(1) : '0;
            if (w_stop || w_fire) begin
                r_state <= S_STOP;
            end else if (w_drive && r_state != S_DEAD && r_state != dir_to_state(w_dir)) begin
                r_state  <= S_DEAD;
                r_target <= w_dir;
            end else if (r_state == S_DEAD) begin
                if (w_drive && w_dir != r_target) begin
                    r_target <= w_dir;
                    r_dt     <= '0;
                end else if (w_dt_done) begin
                    r_state <= dir_to_state(r_target);
                end
            end
        end
    end
    assign in1          = r_in1;
    assign in2          = r_in2;
    assign motor_state  = r_state;
    assign timeout_flag = r_timeout;
    assign pulse_err    = r_pulse_err;
endmodule

// File: tb/tb_motor_pulse_receiver.sv
// tb_motor_pulse_receiver: directed stimulus with a cycle-stamped expectation queue drained by a negedge monitor
module tb_motor_pulse_receiver;
    localparam int K_ST = 0, K_IN1 = 1, K_IN2 = 2, K_TO = 3, K_PE = 4, K_C1 = 5, K_C2 = 6;
    typedef struct {
        int cyc;
        int kind;
        int val;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        forward_rst = 1'b0;
    logic        reverse_rst = 1'b0;
    logic        stop_rst = 1'b0;
    logic [11:0] duty = 12'd3;
    logic        in1;
    logic        in2;
    logic [1:0]  motor_state;
    logic        timeout_flag;
    logic        pulse_err;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [9:0]  h1 = '0;
    logic [9:0]  h2 = '0;
    exp_t        q[$];
    motor_pulse_receiver #(
        .TIMEOUT_CYCLES (100),
        .DEADTIME_CYCLES(4),
        .PWM_PERIOD     (10),
        .DUTY_W         (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .forward_rst (forward_rst),
        .reverse_rst (reverse_rst),
        .stop_rst    (stop_rst),
        .duty        (duty),
        .in1         (in1),
        .in2         (in2),
        .motor_state (motor_state),
        .timeout_flag(timeout_flag),
        .pulse_err   (pulse_err)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic string kind_name(input int k);
        case (k)
            K_ST:    return "motor_state";
            K_IN1:   return "in1";
            K_IN2:   return "in2";
            K_TO:    return "timeout_flag";
            K_PE:    return "pulse_err";
            K_C1:    return "in1_high_per_10";
            default: return "in2_high_per_10";
        endcase
    endfunction
    task automatic check(input exp_t e);
        logic [7:0] act;
        act = (e.kind == K_ST)  ? {6'b0, motor_state} :
              (e.kind == K_IN1) ? {7'b0, in1} :
              (e.kind == K_IN2) ? {7'b0, in2} :
              (e.kind == K_TO)  ? {7'b0, timeout_flag} :
              (e.kind == K_PE)  ? {7'b0, pulse_err} :
              (e.kind == K_C1)  ? 8'($countones(h1)) : 8'($countones(h2));
        checks++;
        if (e.cyc != cyc || act !== 8'(e.val)) begin
            errors++;
            $display("FAIL %s at cycle %0d (seen %0d): got %0d expected %0d", kind_name(e.kind), e.cyc, cyc, act, e.val);
        end
    endtask
    initial forever begin
        @(negedge clk);
        h1 = {h1[8:0], in1};
        h2 = {h2[8:0], in2};
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                check(q[i]);
                q.delete(i);
            end
        end
    end
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic ex(input int dt, input int k, input int v);
        exp_t e;
        e.cyc  = cyc + dt;
        e.kind = k;
        e.val  = v;
        q.push_back(e);
    endtask
    task automatic pulse(input logic f, input logic r, input logic s);
        forward_rst = f;
        reverse_rst = r;
        stop_rst    = s;
        tick(1);
        forward_rst = 1'b0;
        reverse_rst = 1'b0;
        stop_rst    = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
    initial begin
        // reset values
        ex(2, K_ST, 2); ex(2, K_IN1, 0); ex(2, K_IN2, 0); ex(2, K_TO, 0); ex(2, K_PE, 0);
        tick(3);
        rst = 1'b0;
        tick(2);
        // start forward: 4 dead-time cycles then 3/10 PWM on in1
        ex(1, K_ST, 3); ex(2, K_ST, 3); ex(4, K_ST, 3); ex(5, K_ST, 0); ex(5, K_IN1, 0);
        ex(1, K_PE, 0); ex(1, K_TO, 0); ex(20, K_C1, 3); ex(20, K_C2, 0); ex(30, K_C1, 3);
        pulse(1, 0, 0);
        tick(29);
        // same-direction refresh, then duty change mid-period (counter at 5)
        ex(1, K_ST, 0); ex(2, K_ST, 0);
        pulse(1, 0, 0);
        for (int i = 0; i < 10 && ((cyc - 3) % 10) != 5; i++) tick(1);
        duty = 12'd8;
        ex(1, K_IN1, 0); ex(2, K_IN1, 0); ex(3, K_IN1, 0); ex(6, K_IN1, 1);
        ex(13, K_IN1, 1); ex(14, K_IN1, 0); ex(15, K_C1, 8);
        tick(16);
        // duty edges: zero, above period, and a value that needs saturation
        pulse(1, 0, 0);
        duty = 12'd0;
        ex(22, K_C1, 0);
        tick(22);
        duty = 12'd15;
        ex(22, K_C1, 10);
        tick(22);
        duty = 12'd20;
        ex(22, K_C1, 10); ex(22, K_C2, 0);
        tick(22);
        duty = 12'd3;
        tick(12);
        // reversal
        ex(1, K_ST, 3); ex(4, K_ST, 3); ex(5, K_ST, 1); ex(2, K_IN1, 0); ex(5, K_IN1, 0);
        ex(1, K_IN2, 0); ex(5, K_IN2, 0); ex(16, K_C2, 3); ex(16, K_C1, 0);
        pulse(0, 1, 0);
        tick(19);
        // simultaneous pulses: fwd+stop in S_REV, then fwd+rev during dead-time
        ex(1, K_ST, 2); ex(1, K_PE, 1); ex(2, K_PE, 0); ex(2, K_IN2, 0);
        pulse(1, 0, 1);
        tick(1);
        ex(1, K_ST, 3); ex(1, K_PE, 0);
        pulse(1, 0, 0);
        tick(1);
        ex(1, K_ST, 2); ex(1, K_PE, 1); ex(2, K_PE, 0);
        pulse(1, 1, 0);
        tick(3);
        // watchdog: refresh at +50, fire 100 cycles after the last pulse
        ex(1, K_ST, 3); ex(5, K_ST, 0); ex(100, K_ST, 0); ex(101, K_ST, 0);
        ex(150, K_ST, 0); ex(150, K_TO, 0); ex(151, K_ST, 2); ex(151, K_TO, 1);
        ex(152, K_IN1, 0); ex(170, K_TO, 1);
        pulse(1, 0, 0);
        tick(49);
        pulse(1, 0, 0);
        tick(124);
        // flag clears on fwd; a pulse on the timeout cycle beats the watchdog
        ex(1, K_TO, 0); ex(1, K_ST, 3); ex(100, K_ST, 0); ex(101, K_ST, 0);
        ex(102, K_ST, 0); ex(102, K_TO, 0);
        pulse(1, 0, 0);
        tick(99);
        pulse(1, 0, 0);
        tick(3);
        ex(1, K_ST, 2); ex(2, K_IN1, 0); ex(2, K_IN2, 0);
        pulse(0, 0, 1);
        tick(3);
        // reset during dead-time, then a full dead-time again
        ex(1, K_ST, 3); ex(2, K_ST, 3); ex(3, K_ST, 2); ex(3, K_IN1, 0); ex(3, K_IN2, 0);
        ex(3, K_PE, 0); ex(3, K_TO, 0);
        pulse(1, 0, 0);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        ex(1, K_ST, 3); ex(4, K_ST, 3); ex(5, K_ST, 0);
        pulse(1, 0, 0);
        tick(8);
        for (int i = 0; i < 20 && q.size() > 0; i++) tick(1);
        foreach (q[i]) begin
            checks++;
            errors++;
            $display("FAIL %s at cycle %0d: never checked", kind_name(q[i].kind), q[i].cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
